// File: rtl/lsb_queue_pkg.sv
// Shared load/store queue definitions: opcode encodings, access sizes, FSM states
// and the memory-request payload.
package lsb_queue_pkg;

    localparam int unsigned OPK_W = 8;

    localparam logic [OPK_W-1:0] OP_LB  = 8'h01;
    localparam logic [OPK_W-1:0] OP_LH  = 8'h02;
    localparam logic [OPK_W-1:0] OP_LW  = 8'h03;
    localparam logic [OPK_W-1:0] OP_LBU = 8'h04;
    localparam logic [OPK_W-1:0] OP_LHU = 8'h05;
    localparam logic [OPK_W-1:0] OP_SB  = 8'h08;
    localparam logic [OPK_W-1:0] OP_SH  = 8'h09;
    localparam logic [OPK_W-1:0] OP_SW  = 8'h0A;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    typedef enum logic {
        KIND_LOAD  = 1'b0,
        KIND_STORE = 1'b1
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_STORE_WAIT = 2'd2,
        ST_DRAIN      = 2'd3
    } lsb_state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic kind_e op_kind(input logic [OPK_W-1:0] op);
        return (op == OP_SB || op == OP_SH || op == OP_SW) ? KIND_STORE : KIND_LOAD;
    endfunction

    function automatic logic [2:0] op_size(input logic [OPK_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_B;
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            default:              return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsb_queue_load_ext.sv
// Combinational load-data extension: sign/zero extends the low byte/half of the
// returned memory word according to the load opcode.
module lsb_load_ext
    import lsb_queue_pkg::*;
#(
    parameter int unsigned OP_LOG = 6
) (
    input  logic [OP_LOG-1:0] i_op,
    input  logic [31:0]       i_rdata,
    output logic [31:0]       o_value_c
);

    always_comb begin
        o_value_c = i_rdata;
        case (OPK_W'(i_op))
            OP_LB:   o_value_c = {{24{i_rdata[7]}}, i_rdata[7:0]};
            OP_LBU:  o_value_c = {24'h0, i_rdata[7:0]};
            OP_LH:   o_value_c = {{16{i_rdata[15]}}, i_rdata[15:0]};
            OP_LHU:  o_value_c = {16'h0, i_rdata[15:0]};
            default: o_value_c = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store queue: operand wakeup from ALU/load broadcasts, commit-gated
// stores, one outstanding memory request, and flush that keeps committed stores.
module lsb_queue
    import lsb_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ROB_LOG = 4,
    parameter int unsigned OP_LOG  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rdy,
    input  logic                    i_flush,

    input  logic                    i_issue_valid,
    input  logic [OP_LOG-1:0]       i_issue_op,
    input  logic [31:0]             i_issue_vj,
    input  logic [31:0]             i_issue_vk,
    input  logic [31:0]             i_issue_imm,
    input  logic                    i_issue_rj,
    input  logic                    i_issue_rk,
    input  logic [ROB_LOG-1:0]      i_issue_qj,
    input  logic [ROB_LOG-1:0]      i_issue_qk,
    input  logic [ROB_LOG-1:0]      i_issue_rob,

    input  logic                    i_exc_valid,
    input  logic [ROB_LOG-1:0]      i_exc_rob,
    input  logic [31:0]             i_exc_value,

    input  logic                    i_commit_valid,
    input  logic [ROB_LOG-1:0]      i_commit_rob,

    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [2:0]              o_mem_size,
    output logic [31:0]             o_mem_addr,
    output logic [31:0]             o_mem_wdata,
    input  logic                    i_mem_done,
    input  logic [31:0]             i_mem_rdata,

    output logic                    o_out_valid,
    output logic [ROB_LOG-1:0]      o_out_rob,
    output logic [31:0]             o_out_value,

    output logic                    o_full,
    output logic                    o_next_full,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_store;
    logic [DEPTH-1:0]   r_cmt;
    logic [DEPTH-1:0]   r_rj;
    logic [DEPTH-1:0]   r_rk;
    logic [OP_LOG-1:0]  r_op  [DEPTH];
    logic [31:0]        r_vj  [DEPTH];
    logic [31:0]        r_vk  [DEPTH];
    logic [31:0]        r_imm [DEPTH];
    logic [ROB_LOG-1:0] r_qj  [DEPTH];
    logic [ROB_LOG-1:0] r_qk  [DEPTH];
    logic [ROB_LOG-1:0] r_rob [DEPTH];

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_next_full;

    lsb_state_e         r_state;
    lsb_state_e         w_state_nxt;
    mem_req_t           r_mem;
    mem_req_t           w_mem_nxt;
    logic               r_out_valid;
    logic [ROB_LOG-1:0] r_out_rob;
    logic [31:0]        r_out_value;
    logic               w_out_valid_nxt;
    logic [ROB_LOG-1:0] w_out_rob_nxt;
    logic [31:0]        w_out_value_nxt;

    logic               w_issue;
    logic               w_pop;
    logic               w_head_ready;
    logic               w_ld_go;
    logic               w_st_go;
    logic [31:0]        w_ext_value;
    logic [31:0]        w_iss_vj;
    logic [31:0]        w_iss_vk;
    logic               w_iss_rj;
    logic               w_iss_rk;
    logic               w_iss_store;
    logic [DEPTH-1:0]   w_cmt_hit;
    logic [DEPTH-1:0]   w_keep_mask;
    logic [CNT_W-1:0]   w_keep;
    logic               w_run;
    logic [PTR_W-1:0]   w_idx;
    logic [CNT_W-1:0]   w_count_nxt;

    lsb_load_ext #(
        .OP_LOG    (OP_LOG)
    ) u_load_ext (
        .i_op      (r_op[r_head]),
        .i_rdata   (i_mem_rdata),
        .o_value_c (w_ext_value)
    );

    assign w_issue      = i_issue_valid && (r_count != CNT_W'(DEPTH)) && !i_flush;
    assign w_iss_store  = (op_kind(OPK_W'(i_issue_op)) == KIND_STORE);
    assign w_head_ready = r_valid[r_head] && r_rj[r_head] && r_rk[r_head];
    assign w_ld_go      = w_head_ready && !r_store[r_head] && !i_flush;
    assign w_st_go      = w_head_ready && r_store[r_head] && r_cmt[r_head];

    // Same-cycle broadcast bypass for operands arriving at issue
    always_comb begin
        w_iss_vj = i_issue_vj;
        w_iss_rj = i_issue_rj;
        w_iss_vk = i_issue_vk;
        w_iss_rk = i_issue_rk;
        if (!i_issue_rj) begin
            if (i_exc_valid && i_issue_qj == i_exc_rob) begin
                w_iss_vj = i_exc_value;
                w_iss_rj = 1'b1;
            end else if (r_out_valid && i_issue_qj == r_out_rob) begin
                w_iss_vj = r_out_value;
                w_iss_rj = 1'b1;
            end
        end
        if (!i_issue_rk) begin
            if (i_exc_valid && i_issue_qk == i_exc_rob) begin
                w_iss_vk = i_exc_value;
                w_iss_rk = 1'b1;
            end else if (r_out_valid && i_issue_qk == r_out_rob) begin
                w_iss_vk = r_out_value;
                w_iss_rk = 1'b1;
            end
        end
    end

    // Flush survivors: the run of committed stores starting at head, counting this cycle's commit
    always_comb begin
        w_keep      = '0;
        w_keep_mask = '0;
        w_run       = 1'b1;
        w_idx       = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_cmt_hit[i] = i_commit_valid && r_valid[i] && (r_rob[i] == i_commit_rob);
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_idx = r_head + PTR_W'(k);
            if (w_run && r_valid[w_idx] && r_store[w_idx] && (r_cmt[w_idx] || w_cmt_hit[w_idx])) begin
                w_keep             = w_keep + CNT_W'(1);
                w_keep_mask[w_idx] = 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_count_nxt = i_flush ? (w_keep - CNT_W'(w_pop))
                                 : (r_count + CNT_W'(w_issue) - CNT_W'(w_pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_next_full <= 1'b0;
            r_valid     <= '0;
            r_cmt       <= '0;
        end else if (i_rdy) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r_valid[i] && !r_rj[i]) begin
                    if (i_exc_valid && r_qj[i] == i_exc_rob) begin
                        r_vj[i] <= i_exc_value;
                        r_rj[i] <= 1'b1;
                    end else if (r_out_valid && r_qj[i] == r_out_rob) begin
                        r_vj[i] <= r_out_value;
                        r_rj[i] <= 1'b1;
                    end
                end
                if (r_valid[i] && !r_rk[i]) begin
                    if (i_exc_valid && r_qk[i] == i_exc_rob) begin
                        r_vk[i] <= i_exc_value;
                        r_rk[i] <= 1'b1;
                    end else if (r_out_valid && r_qk[i] == r_out_rob) begin
                        r_vk[i] <= r_out_value;
                        r_rk[i] <= 1'b1;
                    end
                end
                if (w_cmt_hit[i]) begin
                    r_cmt[i] <= 1'b1;
                end
                if (i_flush && !w_keep_mask[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (i_flush) begin
                r_tail <= r_head + w_keep[PTR_W-1:0];
            end else if (w_issue) begin
                r_valid[r_tail] <= 1'b1;
                r_store[r_tail] <= w_iss_store;
                r_cmt[r_tail]   <= !w_iss_store;
                r_op[r_tail]    <= i_issue_op;
                r_vj[r_tail]    <= w_iss_vj;
                r_vk[r_tail]    <= w_iss_vk;
                r_rj[r_tail]    <= w_iss_rj;
                r_rk[r_tail]    <= w_iss_rk;
                r_imm[r_tail]   <= i_issue_imm;
                r_qj[r_tail]    <= i_issue_qj;
                r_qk[r_tail]    <= i_issue_qk;
                r_rob[r_tail]   <= i_issue_rob;
                r_tail          <= r_tail + PTR_W'(1);
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CNT_W'(DEPTH));
            r_next_full <= (w_count_nxt >= CNT_W'(DEPTH - 1));
        end
    end

    // Memory FSM: state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem       <= '0;
            r_out_valid <= 1'b0;
            r_out_rob   <= '0;
            r_out_value <= '0;
        end else if (i_rdy) begin
            r_state     <= w_state_nxt;
            r_mem       <= w_mem_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_rob   <= w_out_rob_nxt;
            r_out_value <= w_out_value_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_nxt       = r_mem;
        w_out_valid_nxt = 1'b0;
        w_out_rob_nxt   = r_out_rob;
        w_out_value_nxt = r_out_value;
        w_pop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ld_go) begin
                    w_mem_nxt.req   = 1'b1;
                    w_mem_nxt.we    = 1'b0;
                    w_mem_nxt.size  = op_size(OPK_W'(r_op[r_head]));
                    w_mem_nxt.addr  = r_vj[r_head] + r_imm[r_head];
                    w_mem_nxt.wdata = 32'h0;
                    w_state_nxt     = ST_LOAD_WAIT;
                end else if (w_st_go) begin
                    w_mem_nxt.req   = 1'b1;
                    w_mem_nxt.we    = 1'b1;
                    w_mem_nxt.size  = op_size(OPK_W'(r_op[r_head]));
                    w_mem_nxt.addr  = r_vj[r_head] + r_imm[r_head];
                    w_mem_nxt.wdata = r_vk[r_head];
                    w_state_nxt     = ST_STORE_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (i_mem_done) begin
                    w_mem_nxt.req = 1'b0;
                    w_state_nxt   = ST_IDLE;
                    // A flush on the completion cycle has already discarded the load
                    if (!i_flush) begin
                        w_pop           = 1'b1;
                        w_out_valid_nxt = 1'b1;
                        w_out_rob_nxt   = r_rob[r_head];
                        w_out_value_nxt = w_ext_value;
                    end
                end else if (i_flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_STORE_WAIT: begin
                if (i_mem_done) begin
                    w_pop         = 1'b1;
                    w_mem_nxt.req = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_mem_done) begin
                    w_mem_nxt.req = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_mem_req   = r_mem.req;
    assign o_mem_we    = r_mem.we;
    assign o_mem_size  = r_mem.size;
    assign o_mem_addr  = r_mem.addr;
    assign o_mem_wdata = r_mem.wdata;
    assign o_out_valid = r_out_valid;
    assign o_out_rob   = r_out_rob;
    assign o_out_value = r_out_value;
    assign o_full      = r_full;
    assign o_next_full = r_next_full;
    assign o_count     = r_count;

endmodule

// File: tb/tb_lsb_queue.sv
// Directed self-checking bench for lsb_queue with hand-computed expectations.
module tb_lsb_queue;
    import lsb_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_rdy;
    logic        i_flush;
    logic        i_issue_valid;
    logic [5:0]  i_issue_op;
    logic [31:0] i_issue_vj;
    logic [31:0] i_issue_vk;
    logic [31:0] i_issue_imm;
    logic        i_issue_rj;
    logic        i_issue_rk;
    logic [3:0]  i_issue_qj;
    logic [3:0]  i_issue_qk;
    logic [3:0]  i_issue_rob;
    logic        i_exc_valid;
    logic [3:0]  i_exc_rob;
    logic [31:0] i_exc_value;
    logic        i_commit_valid;
    logic [3:0]  i_commit_rob;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [2:0]  o_mem_size;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_done;
    logic [31:0] i_mem_rdata;
    logic        o_out_valid;
    logic [3:0]  o_out_rob;
    logic [31:0] o_out_value;
    logic        o_full;
    logic        o_next_full;
    logic [4:0]  o_count;

    int n_chk  = 0;
    int n_pass = 0;

    lsb_queue #(
        .DEPTH   (16),
        .ROB_LOG (4),
        .OP_LOG  (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rdy          (i_rdy),
        .i_flush        (i_flush),
        .i_issue_valid  (i_issue_valid),
        .i_issue_op     (i_issue_op),
        .i_issue_vj     (i_issue_vj),
        .i_issue_vk     (i_issue_vk),
        .i_issue_imm    (i_issue_imm),
        .i_issue_rj     (i_issue_rj),
        .i_issue_rk     (i_issue_rk),
        .i_issue_qj     (i_issue_qj),
        .i_issue_qk     (i_issue_qk),
        .i_issue_rob    (i_issue_rob),
        .i_exc_valid    (i_exc_valid),
        .i_exc_rob      (i_exc_rob),
        .i_exc_value    (i_exc_value),
        .i_commit_valid (i_commit_valid),
        .i_commit_rob   (i_commit_rob),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_size     (o_mem_size),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_done     (i_mem_done),
        .i_mem_rdata    (i_mem_rdata),
        .o_out_valid    (o_out_valid),
        .o_out_rob      (o_out_rob),
        .o_out_value    (o_out_value),
        .o_full         (o_full),
        .o_next_full    (o_next_full),
        .o_count        (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic rj, input logic rk,
                         input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] rob);
        i_issue_valid = 1'b1;
        i_issue_op    = op[5:0];
        i_issue_vj    = vj;
        i_issue_vk    = vk;
        i_issue_imm   = imm;
        i_issue_rj    = rj;
        i_issue_rk    = rk;
        i_issue_qj    = qj;
        i_issue_qk    = qk;
        i_issue_rob   = rob;
        tick();
        i_issue_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!o_mem_req && n < 20) begin
            tick();
            n++;
        end
        chk(tag, o_mem_req, 1);
    endtask

    task automatic mem_done(input logic [31:0] rdata);
        i_mem_done  = 1'b1;
        i_mem_rdata = rdata;
        tick();
        i_mem_done  = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] op, input logic [31:0] rdata,
                           input logic [2:0] sz, input logic [31:0] exp, input string tag);
        issue(op, 32'h1000, 32'h0, 32'h10, 1'b1, 1'b1, 4'd0, 4'd0, 4'd9);
        wait_req({tag, "_req"});
        chk({tag, "_size"}, o_mem_size, sz);
        chk({tag, "_addr"}, o_mem_addr, 32'h1010);
        mem_done(rdata);
        chk({tag, "_outv"}, o_out_valid, 1);
        chk({tag, "_value"}, o_out_value, exp);
        chk({tag, "_rob"}, o_out_rob, 9);
        tick();
        chk({tag, "_outv_drop"}, o_out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; i_rdy = 1'b1; i_flush = 1'b0;
        i_issue_valid = 1'b0; i_issue_op = '0; i_issue_vj = '0; i_issue_vk = '0;
        i_issue_imm = '0; i_issue_rj = 1'b0; i_issue_rk = 1'b0; i_issue_qj = '0;
        i_issue_qk = '0; i_issue_rob = '0; i_exc_valid = 1'b0; i_exc_rob = '0;
        i_exc_value = '0; i_commit_valid = 1'b0; i_commit_rob = '0;
        i_mem_done = 1'b0; i_mem_rdata = '0;
        tick(); tick();
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        chk("rst_next_full", o_next_full, 0);
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_out_valid", o_out_valid, 0);
        rst = 1'b0;
        tick();

        // LW with hold check
        issue(OP_LW, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 4'd0, 4'd0, 4'd1);
        chk("lw_count", o_count, 1);
        wait_req("lw_req");
        chk("lw_addr", o_mem_addr, 32'h104);
        chk("lw_size", o_mem_size, 3'b100);
        chk("lw_we", o_mem_we, 0);
        tick(); tick();
        chk("lw_hold_req", o_mem_req, 1);
        chk("lw_hold_addr", o_mem_addr, 32'h104);
        chk("lw_out_early", o_out_valid, 0);
        mem_done(32'hDEADBEEF);
        chk("lw_outv", o_out_valid, 1);
        chk("lw_value", o_out_value, 32'hDEADBEEF);
        chk("lw_rob", o_out_rob, 1);
        chk("lw_req_drop", o_mem_req, 0);
        chk("lw_count_pop", o_count, 0);
        tick();
        chk("lw_outv_1cyc", o_out_valid, 0);

        do_load(OP_LB,  32'h80,   3'b001, 32'hFFFFFF80, "lb");
        do_load(OP_LBU, 32'h80,   3'b001, 32'h00000080, "lbu");
        do_load(OP_LH,  32'h8000, 3'b010, 32'hFFFF8000, "lh");
        do_load(OP_LHU, 32'h8000, 3'b010, 32'h00008000, "lhu");

        // SW with vk waiting on tag 3, then commit
        issue(OP_SW, 32'h200, 32'h0, 32'h8, 1'b1, 1'b0, 4'd0, 4'd3, 4'd5);
        tick(); tick();
        chk("sw_no_req_pending", o_mem_req, 0);
        i_exc_valid = 1'b1; i_exc_rob = 4'd3; i_exc_value = 32'h55;
        tick();
        i_exc_valid = 1'b0;
        tick(); tick();
        chk("sw_no_req_uncommitted", o_mem_req, 0);
        i_commit_valid = 1'b1; i_commit_rob = 4'd5;
        tick();
        i_commit_valid = 1'b0;
        wait_req("sw_req");
        chk("sw_we", o_mem_we, 1);
        chk("sw_wdata", o_mem_wdata, 32'h55);
        chk("sw_addr", o_mem_addr, 32'h208);
        tick();
        chk("sw_hold", o_mem_req, 1);
        chk("sw_count_held", o_count, 1);
        mem_done(32'h0);
        chk("sw_req_drop", o_mem_req, 0);
        chk("sw_count_pop", o_count, 0);

        // Issue-cycle bypass of an ALU broadcast
        i_exc_valid = 1'b1; i_exc_rob = 4'd4; i_exc_value = 32'h77;
        issue(OP_SW, 32'h500, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd6);
        i_exc_valid = 1'b0;
        i_commit_valid = 1'b1; i_commit_rob = 4'd6;
        tick();
        i_commit_valid = 1'b0;
        wait_req("byp_req");
        chk("byp_wdata", o_mem_wdata, 32'h77);
        mem_done(32'h0);
        chk("byp_count", o_count, 0);

        // Fill to DEPTH with loads that never become ready
        for (int i = 0; i < 15; i++)
            issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd13, 4'd0, 4'(i));
        chk("fill15_count", o_count, 15);
        chk("fill15_next_full", o_next_full, 1);
        chk("fill15_full", o_full, 0);
        issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd13, 4'd0, 4'd15);
        chk("fill16_full", o_full, 1);
        chk("fill16_count", o_count, 16);
        issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("fill_drop_count", o_count, 16);
        chk("fill_no_req", o_mem_req, 0);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        chk("fill_flush_count", o_count, 0);
        chk("fill_flush_full", o_full, 0);

        // Two committed stores survive a flush, loads are discarded
        issue(OP_SW, 32'h300, 32'h11, 32'h0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd1);
        issue(OP_SW, 32'h304, 32'h22, 32'h0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd2);
        issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd12, 4'd0, 4'd3);
        issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd12, 4'd0, 4'd4);
        issue(OP_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'd12, 4'd0, 4'd5);
        chk("fl_count5", o_count, 5);
        i_commit_valid = 1'b1; i_commit_rob = 4'd1;
        tick();
        i_commit_rob = 4'd2; i_flush = 1'b1;
        tick();
        i_commit_valid = 1'b0; i_flush = 1'b0;
        chk("fl_count2", o_count, 2);
        wait_req("fl_st1_req");
        chk("fl_st1_addr", o_mem_addr, 32'h300);
        chk("fl_st1_wdata", o_mem_wdata, 32'h11);
        mem_done(32'h0);
        chk("fl_count1", o_count, 1);
        wait_req("fl_st2_req");
        chk("fl_st2_addr", o_mem_addr, 32'h304);
        chk("fl_st2_wdata", o_mem_wdata, 32'h22);
        mem_done(32'h0);
        chk("fl_count0", o_count, 0);

        // Flush while a load is outstanding
        issue(OP_LW, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd6);
        wait_req("dr_req");
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        chk("dr_req_held", o_mem_req, 1);
        chk("dr_addr_held", o_mem_addr, 32'h400);
        chk("dr_count", o_count, 0);
        tick();
        chk("dr_req_held2", o_mem_req, 1);
        mem_done(32'hAAAA5555);
        chk("dr_req_drop", o_mem_req, 0);
        chk("dr_no_out", o_out_valid, 0);
        tick();
        chk("dr_no_out2", o_out_valid, 0);
        do_load(OP_LW, 32'h1234, 3'b100, 32'h1234, "dr_after");

        // Reset in the middle of a load
        issue(OP_LW, 32'h600, 32'h0, 32'h0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd7);
        wait_req("rm_req");
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rm_req", o_mem_req, 0);
        chk("rm_count", o_count, 0);
        mem_done(32'hFFFF0000);
        chk("rm_no_out", o_out_valid, 0);
        chk("rm_no_req", o_mem_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
